// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - cache-side and memory-side bus bundle for mem_arbiter
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 256
);
    logic              p0_enable_i;
    logic              p0_write_i;
    logic [ADDR_W-1:0] p0_addr_i;
    logic [DATA_W-1:0] p0_data_i;
    logic [DATA_W-1:0] p0_data_o;
    logic              p0_ack_o;

    logic              p1_enable_i;
    logic              p1_write_i;
    logic [ADDR_W-1:0] p1_addr_i;
    logic [DATA_W-1:0] p1_data_i;
    logic [DATA_W-1:0] p1_data_o;
    logic              p1_ack_o;

    logic              mem_enable_o;
    logic              mem_write_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_data_o;
    logic [DATA_W-1:0] mem_data_i;
    logic              mem_ack_i;

    modport slave (
        input  p0_enable_i, p0_write_i, p0_addr_i, p0_data_i,
        output p0_data_o, p0_ack_o,
        input  p1_enable_i, p1_write_i, p1_addr_i, p1_data_i,
        output p1_data_o, p1_ack_o,
        output mem_enable_o, mem_write_o, mem_addr_o, mem_data_o,
        input  mem_data_i, mem_ack_i
    );

    modport master (
        output p0_enable_i, p0_write_i, p0_addr_i, p0_data_i,
        input  p0_data_o, p0_ack_o,
        output p1_enable_i, p1_write_i, p1_addr_i, p1_data_i,
        input  p1_data_o, p1_ack_o,
        input  mem_enable_o, mem_write_o, mem_addr_o, mem_data_o,
        output mem_data_i, mem_ack_i
    );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin two-port line arbiter for a shared data memory
module mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 256,
    parameter int TIMEOUT = 1023
) (
    input  logic          clk_i,
    input  logic          rst_i,
    mem_arbiter_if.slave  bus,
    output logic          grant_o,
    output logic          busy_o,
    output logic          err_o
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, BUSY, RELEASE} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              last_grant_q, last_grant_d;
    logic              grant_q, grant_d;
    logic              busy_q, busy_d;
    logic              err_q, err_d;
    logic              mem_enable_q, mem_enable_d;
    logic              mem_write_q, mem_write_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_data_q, mem_data_d;
    logic [DATA_W-1:0] p0_data_q, p0_data_d;
    logic [DATA_W-1:0] p1_data_q, p1_data_d;
    logic              p0_ack_q, p0_ack_d;
    logic              p1_ack_q, p1_ack_d;
    logic              winner;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            last_grant_q <= 1'b1;
            grant_q      <= 1'b0;
            busy_q       <= 1'b0;
            err_q        <= 1'b0;
            mem_enable_q <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_data_q   <= '0;
            p0_data_q    <= '0;
            p1_data_q    <= '0;
            p0_ack_q     <= 1'b0;
            p1_ack_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            busy_q       <= busy_d;
            err_q        <= err_d;
            mem_enable_q <= mem_enable_d;
            mem_write_q  <= mem_write_d;
            mem_addr_q   <= mem_addr_d;
            mem_data_q   <= mem_data_d;
            p0_data_q    <= p0_data_d;
            p1_data_q    <= p1_data_d;
            p0_ack_q     <= p0_ack_d;
            p1_ack_q     <= p1_ack_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        err_d        = err_q;
        mem_enable_d = mem_enable_q;
        mem_write_d  = mem_write_q;
        mem_addr_d   = mem_addr_q;
        mem_data_d   = mem_data_q;
        p0_data_d    = p0_data_q;
        p1_data_d    = p1_data_q;
        p0_ack_d     = p0_ack_q;
        p1_ack_d     = p1_ack_q;
        winner       = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.p0_enable_i || bus.p1_enable_i) begin
                    // On contention the port that did not win last time goes first.
                    winner       = (bus.p0_enable_i && bus.p1_enable_i) ? ~last_grant_q
                                                                        : bus.p1_enable_i;
                    mem_addr_d   = winner ? bus.p1_addr_i  : bus.p0_addr_i;
                    mem_data_d   = winner ? bus.p1_data_i  : bus.p0_data_i;
                    mem_write_d  = winner ? bus.p1_write_i : bus.p0_write_i;
                    mem_enable_d = 1'b1;
                    grant_d      = winner;
                    last_grant_d = winner;
                    cnt_d        = '0;
                    state_d      = BUSY;
                end
            end
            BUSY: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (bus.mem_ack_i) begin
                    if (!mem_write_q) begin
                        if (grant_q) p1_data_d = bus.mem_data_i;
                        else         p0_data_d = bus.mem_data_i;
                    end
                    p0_ack_d     = ~grant_q;
                    p1_ack_d     = grant_q;
                    mem_enable_d = 1'b0;
                    mem_write_d  = 1'b0;
                    state_d      = RELEASE;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    // Abort: requester still gets its ack so it never hangs; err_o records it.
                    err_d        = 1'b1;
                    p0_ack_d     = ~grant_q;
                    p1_ack_d     = grant_q;
                    mem_enable_d = 1'b0;
                    mem_write_d  = 1'b0;
                    state_d      = RELEASE;
                end
            end
            RELEASE: begin
                p0_ack_d = 1'b0;
                p1_ack_d = 1'b0;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    assign bus.mem_enable_o = mem_enable_q;
    assign bus.mem_write_o  = mem_write_q;
    assign bus.mem_addr_o   = mem_addr_q;
    assign bus.mem_data_o   = mem_data_q;
    assign bus.p0_data_o    = p0_data_q;
    assign bus.p1_data_o    = p1_data_q;
    assign bus.p0_ack_o     = p0_ack_q;
    assign bus.p1_ack_o     = p1_ack_q;
    assign grant_o          = grant_q;
    assign busy_o           = busy_q;
    assign err_o            = err_q;
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Two-port arbiter that lets the instruction cache (port 0) and the data cache (port 1) share one 256-bit line-wide data memory.
It accepts line read/write requests from both caches and issues one transaction at a time to memory. It then returns the memory acknowledge and read line to the winning requester.
It sits between the CPU's cache controllers and the external data memory interface (mem_data_i/mem_ack_i/mem_data_o/mem_addr_o/mem_enable_o/mem_write_o).

Parameters:
ADDR_W, 32, address width in bits.
DATA_W, 256, cache line width in bits.
TIMEOUT, 1023, max BUSY cycles without mem_ack_i before abort; must be >= 2.

Ports:
clk_i  in  1  clock; all logic on rising edge.
rst_i  in  1  reset, synchronous, active-high.
p0_enable_i  in  1  port 0 request; held high until p0_ack_o seen.
p0_write_i  in  1  port 0: 1 = write line, 0 = read line.
p0_addr_i  in  ADDR_W  port 0 line address.
p0_data_i  in  DATA_W  port 0 write line.
p0_data_o  out  DATA_W  port 0 last read line.
p0_ack_o  out  1  port 0 completion pulse.
p1_enable_i, p1_write_i, p1_addr_i, p1_data_i, p1_data_o, p1_ack_o: same as port 0, for port 1.
mem_enable_o  out  1  memory request.
mem_write_o  out  1  memory write strobe.
mem_addr_o  out  ADDR_W  memory address.
mem_data_o  out  DATA_W  memory write data.
mem_data_i  in  DATA_W  memory read data, valid with mem_ack_i.
mem_ack_i  in  1  memory completion, 1 cycle.
grant_o  out  1  port owning the current or last transaction.
busy_o  out  1  state != IDLE.
err_o  out  1  sticky timeout flag.

Behaviour:
- All outputs are registered.
- Reset values:
  - state = IDLE; all mem_* outputs = 0.
  - both ack_o = 0; both data_o = 0.
  - grant_o = 0; err_o = 0; last_grant = 1.
  - timeout counter = 0.
- Reset mid-transaction aborts it silently: no ack is issued and mem_enable_o = 0 after the reset edge.
- FSM has three states: IDLE, BUSY, RELEASE.
- IDLE:
  - If exactly one enable is high, that port wins. If both are high, the port != last_grant wins (round-robin).
  - On the same edge: latch winner's addr/write/data into the mem_* registers; set mem_enable_o = 1; set grant_o = last_grant = winner; clear counter; go to BUSY.
  - Request sampled at edge N gives mem_enable_o = 1 from edge N onward (visible in cycle N+1).
  - With no enable, stay in IDLE.
- BUSY:
  - mem_enable_o/mem_write_o/mem_addr_o/mem_data_o hold the latched values. Upstream input changes are ignored.
  - Counter increments each cycle.
  - On mem_ack_i = 1:
    - If the transaction is a read, capture mem_data_i into p<grant>_data_o.
    - Set p<grant>_ack_o = 1 and mem_enable_o = 0, mem_write_o = 0; go to RELEASE.
  - On a write, p<grant>_data_o is unchanged.
  - If mem_ack_i is not seen and counter reaches TIMEOUT-1:
    - Set err_o = 1 (sticky until rst_i); p<grant>_ack_o = 1; mem_enable_o = 0.
    - p<grant>_data_o is unchanged; go to RELEASE.
  - A coincident ack on the timeout cycle counts as normal completion; err_o is not set.
- RELEASE:
  - Lasts exactly 1 cycle with the ack pulse visible. No arbitration; enables are ignored.
  - Next edge: ack_o = 0; go to IDLE.
  - Requesters must deassert enable on the edge where they sample ack_o = 1. An enable still high in IDLE is a new request.
- mem_ack_i is ignored outside BUSY.
- The non-granted port's ack_o is never asserted. Its data_o never changes.
- At most one ack_o is high in any cycle.
- Minimum transaction occupancy is 3 cycles (IDLE→BUSY→RELEASE→IDLE). Back-to-back throughput is one transaction per (memory latency + 2) cycles.

Test Plan:
1. Read on port 1 only: p1 reads addr 0x40; memory acks 10 cycles after mem_enable_o with data 256'hA5…A5.
   - Expect mem_addr_o = 0x40, mem_write_o = 0, mem_enable_o high for 10 cycles.
   - Expect a 1-cycle p1_ack_o, p1_data_o = A5…A5, p0_ack_o = 0, grant_o = 1.
2. Round-robin: both ports request reads right after reset; each re-requests after its ack, three times in total.
   - Expect grant sequence p0, p1, p0.
   - Expect each ack_o pulse to occur only for the granted port.
3. Write on port 1: p1 writes addr 0x80 with data D = 256'h1234_…_CDEF.
   - Expect mem_write_o = 1, mem_addr_o = 0x80, mem_data_o = D throughout BUSY.
   - Expect p1_data_o unchanged (0) after ack.
4. Input stability: p0_addr_i changes from 0x100 to 0x200 mid-BUSY.
   - Expect mem_addr_o to stay 0x100 until ack.
5. Timeout: TIMEOUT = 16, mem_ack_i held 0.
   - Expect mem_enable_o to drop after 16 BUSY cycles, p0_ack_o to pulse, err_o = 1.
   - Expect err_o to stay 1 across later successful transactions until rst_i.
6. Reset mid-BUSY: assert rst_i mid-BUSY, then inject a late mem_ack_i.
   - Expect all outputs 0 and state IDLE after the reset edge.
   - Expect the late mem_ack_i to produce no ack_o.
